// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// The pipeline is stalled while a miss fill or a store runs against the multi-cycle backing memory.
module data_cache #(
  parameter int INDEX_BITS  = 6,
  parameter int MEM_LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_cpu_address,
  input  logic [31:0] i_cpu_write_data,
  input  logic        i_cpu_mem_read,
  input  logic        i_cpu_mem_write,
  output logic [31:0] o_cpu_read_data,
  output logic        o_stall,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  input  logic [31:0] i_mem_read_data,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 14 - INDEX_BITS;
  localparam int CW       = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAT_C = CW'(MEM_LATENCY);

  typedef enum logic [1:0] {IDLE, READ_MISS, WRITE} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_cnt;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag [LINES];
  logic [31:0]           r_data [LINES];

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_latIdx;
  logic [TAG_BITS-1:0]   w_latTag;
  logic                  w_hit;
  logic                  w_latHit;
  logic                  w_lastCycle;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  assign w_idx       = i_cpu_address[INDEX_BITS+1:2];
  assign w_tag       = i_cpu_address[15:INDEX_BITS+2];
  assign w_latIdx    = r_addr[INDEX_BITS+1:2];
  assign w_latTag    = r_addr[15:INDEX_BITS+2];
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_latHit    = r_valid[w_latIdx] && (r_tag[w_latIdx] == w_latTag);
  assign w_lastCycle = (r_cnt == LAT_C);
  assign w_unused    = &{1'b0, i_cpu_address[31:16], i_cpu_address[1:0]};

  assign o_cpu_read_data  = i_cpu_mem_read ? w_rdata : 32'bz;
  assign o_mem_write_data = r_wdata;

  always_comb begin
    w_next        = r_state;
    o_stall       = 1'b0;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    o_mem_address = i_cpu_address;
    w_rdata       = r_data[w_idx];
    case (r_state)
      IDLE: begin
        if (i_cpu_mem_write) begin
          o_stall = 1'b1;
          w_next  = WRITE;
        end else if (i_cpu_mem_read && !w_hit) begin
          o_stall = 1'b1;
          w_next  = READ_MISS;
        end
      end
      READ_MISS: begin
        o_mem_read    = 1'b1;
        o_mem_address = r_addr;
        if (w_lastCycle) begin
          w_rdata = i_mem_read_data;
          w_next  = IDLE;
        end else begin
          o_stall = 1'b1;
        end
      end
      WRITE: begin
        o_mem_address = r_addr;
        if (w_lastCycle) begin
          o_mem_write = 1'b1;
          w_next      = IDLE;
        end else begin
          o_stall = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
    // Reset must silence the memory side even if an access was in flight.
    if (i_rst) begin
      o_stall     = 1'b0;
      o_mem_read  = 1'b0;
      o_mem_write = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_valid      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      o_hit_count  <= '0;
      o_miss_count <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (i_cpu_mem_write) begin
            r_addr  <= i_cpu_address;
            r_wdata <= i_cpu_write_data;
            r_cnt   <= CW'(1);
          end else if (i_cpu_mem_read) begin
            if (w_hit) begin
              o_hit_count <= o_hit_count + 32'd1;
            end else begin
              r_addr       <= i_cpu_address;
              r_cnt        <= CW'(1);
              o_miss_count <= o_miss_count + 32'd1;
            end
          end
        end
        READ_MISS: begin
          if (w_lastCycle) r_valid[w_latIdx] <= 1'b1;
          else             r_cnt <= r_cnt + CW'(1);
        end
        WRITE: begin
          if (!w_lastCycle) r_cnt <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Line payload and tags need no reset: the valid bits alone decide hits.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == READ_MISS && w_lastCycle) begin
        r_data[w_latIdx] <= i_mem_read_data;
        r_tag[w_latIdx]  <= w_latTag;
      end else if (r_state == WRITE && w_lastCycle && w_latHit) begin
        r_data[w_latIdx] <= r_wdata;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios with literal expectations,
// then randomized loads/stores checked cycle by cycle against a transaction-level model.
module tb_data_cache;

  localparam int INDEX_BITS = 6;
  localparam int LAT        = 2;
  localparam int LINES      = 1 << INDEX_BITS;
  localparam int WORDS      = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpuAddress;
  logic [31:0] cpuWriteData;
  logic        cpuMemRead;
  logic        cpuMemWrite;
  wire  [31:0] cpuReadData;
  logic        stall;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] hitCount;
  logic [31:0] missCount;

  int checks = 0;
  int errors = 0;

  data_cache #(.INDEX_BITS(INDEX_BITS), .MEM_LATENCY(LAT)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_cpu_address   (cpuAddress),
    .i_cpu_write_data(cpuWriteData),
    .i_cpu_mem_read  (cpuMemRead),
    .i_cpu_mem_write (cpuMemWrite),
    .o_cpu_read_data (cpuReadData),
    .o_stall         (stall),
    .o_mem_address   (memAddress),
    .o_mem_write_data(memWriteData),
    .i_mem_read_data (memReadData),
    .o_mem_read      (memRead),
    .o_mem_write     (memWrite),
    .o_hit_count     (hitCount),
    .o_miss_count    (missCount)
  );

  always #5 clk = ~clk;

  // Backing memory: untouched words read back a fixed pattern; word 1 (byte 0x4) holds 0x0000FFFF.
  function automatic logic [31:0] initPattern(input int w);
    if (w == 1) return 32'h0000FFFF;
    return (w * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  bit [31:0] mem [WORDS];
  bit        memWritten [WORDS];
  int        writePulses = 0;

  assign memReadData = memWritten[memAddress[15:2]] ? mem[memAddress[15:2]]
                                                    : initPattern(int'(memAddress[15:2]));

  always @(posedge clk) begin
    if (memWrite) begin
      mem[memAddress[15:2]]        <= memWriteData;
      memWritten[memAddress[15:2]] <= 1'b1;
      writePulses                  <= writePulses + 1;
    end
  end

  // Reference model: architectural memory contents plus which word each line currently holds.
  bit [31:0] refMem [WORDS];
  bit        refWritten [WORDS];
  bit        refValid [LINES];
  int        refWord [LINES];
  int        refHits;
  int        refMisses;
  int        refPulses = 0;

  function automatic logic [31:0] refRead(input int w);
    return refWritten[w] ? refMem[w] : initPattern(w);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < LINES; i++) refValid[i] = 1'b0;
    refHits   = 0;
    refMisses = 0;
  endtask

  // Drives one request from an IDLE cycle and checks every cycle until it completes.
  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                               input logic [31:0] data, output logic [31:0] readVal);
    int  w;
    int  idx;
    bit  hit;
    int  lastK;
    logic [31:0] expData;
    w       = int'(addr[15:2]);
    idx     = w % LINES;
    hit     = !isWrite && refValid[idx] && (refWord[idx] == w);
    lastK   = hit ? 0 : LAT;
    expData = refRead(w);
    readVal = 32'h0;
    cpuAddress   = addr;
    cpuWriteData = data;
    cpuMemRead   = !isWrite;
    cpuMemWrite  = isWrite;
    for (int k = 0; k <= lastK; k++) begin
      @(negedge clk);
      checkOutput("stall", {31'b0, stall}, {31'b0, (k < lastK)});
      checkOutput("mem_read", {31'b0, memRead}, {31'b0, (!isWrite && !hit && k >= 1)});
      checkOutput("mem_write", {31'b0, memWrite}, {31'b0, (isWrite && k == LAT)});
      if (memRead || memWrite)
        checkOutput("mem_address", {18'b0, memAddress[15:2]}, {18'b0, addr[15:2]});
      if (isWrite && k == LAT)
        checkOutput("mem_write_data", memWriteData, data);
      if (!isWrite && k == lastK) begin
        checkOutput("read_data", cpuReadData, expData);
        readVal = cpuReadData;
      end
      if (k < lastK) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    cpuMemRead  = 1'b0;
    cpuMemWrite = 1'b0;
    if (isWrite) begin
      refMem[w]     = data;
      refWritten[w] = 1'b1;
      refPulses++;
    end else if (hit) begin
      refHits++;
    end else begin
      refMisses++;
      refValid[idx] = 1'b1;
      refWord[idx]  = w;
    end
    checkOutput("hit_count", hitCount, refHits);
    checkOutput("miss_count", missCount, refMisses);
    checkOutput("write_pulses", writePulses, refPulses);
  endtask

  // Starts a miss or store, then resets one cycle in, while the access is still pending.
  task automatic resetMidAccess(input bit isWrite, input logic [31:0] addr, input logic [31:0] data);
    cpuAddress   = addr;
    cpuWriteData = data;
    cpuMemRead   = !isWrite;
    cpuMemWrite  = isWrite;
    @(negedge clk);
    checkOutput("abort_req_stall", {31'b0, stall}, 32'd1);
    @(posedge clk);
    #1;
    rst         = 1'b1;
    cpuMemRead  = 1'b0;
    cpuMemWrite = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("rst_stall", {31'b0, stall}, 32'd0);
      checkOutput("rst_mem_read", {31'b0, memRead}, 32'd0);
      checkOutput("rst_mem_write", {31'b0, memWrite}, 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    modelReset();
    checkOutput("rst_hit_count", hitCount, 32'd0);
    checkOutput("rst_miss_count", missCount, 32'd0);
    checkOutput("rst_write_pulses", writePulses, refPulses);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rv;
    logic [31:0] a;
    rst          = 1'b1;
    cpuAddress   = 32'h0;
    cpuWriteData = 32'h0;
    cpuMemRead   = 1'b0;
    cpuMemWrite  = 1'b0;
    modelReset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checkOutput("init_stall", {31'b0, stall}, 32'd0);
      checkOutput("init_mem_read", {31'b0, memRead}, 32'd0);
      checkOutput("init_mem_write", {31'b0, memWrite}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("init_hit_count", hitCount, 32'd0);
    checkOutput("init_miss_count", missCount, 32'd0);

    applyStimulus(1'b0, 32'h0000_0004, 32'h0, rv);
    checkOutput("lit_first_read", rv, 32'h0000FFFF);
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, rv);
    checkOutput("lit_reread", rv, 32'h0000FFFF);
    checkOutput("lit_hits_1", hitCount, 32'd1);
    checkOutput("lit_misses_1", missCount, 32'd1);

    applyStimulus(1'b1, 32'h0000_0004, 32'hFFFF0000, rv);
    checkOutput("lit_mem_word1", mem[1], 32'hFFFF0000);
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, rv);
    checkOutput("lit_write_hit_data", rv, 32'hFFFF0000);
    checkOutput("lit_hits_2", hitCount, 32'd2);

    applyStimulus(1'b1, 32'h0000_002C, 32'hCAFEF00D, rv);
    applyStimulus(1'b0, 32'h0000_002C, 32'h0, rv);
    checkOutput("lit_noalloc_data", rv, 32'hCAFEF00D);
    checkOutput("lit_misses_2", missCount, 32'd2);

    applyStimulus(1'b0, 32'h0000_0000, 32'h0, rv);
    applyStimulus(1'b0, 32'h0000_0100, 32'h0, rv);
    applyStimulus(1'b0, 32'h0000_0000, 32'h0, rv);
    checkOutput("lit_evict_misses", missCount, 32'd5);
    checkOutput("lit_evict_hits", hitCount, 32'd2);

    resetMidAccess(1'b0, 32'h0000_0200, 32'h0);
    applyStimulus(1'b0, 32'h0000_0200, 32'h0, rv);
    checkOutput("lit_after_rst_miss", missCount, 32'd1);

    resetMidAccess(1'b1, 32'h0000_0004, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h0000_0004, 32'h0, rv);
    checkOutput("lit_abandoned_write", rv, 32'hFFFF0000);
    checkOutput("lit_abandoned_miss", missCount, 32'd1);

    // Small tag/index pool so hits, evictions and write-hits all occur; ignored address bits are randomized.
    for (int n = 0; n < 400; n++) begin
      a = ($urandom & 32'hFFFF_0000)
        | (32'($urandom_range(0, 3)) << (INDEX_BITS + 2))
        | (32'($urandom_range(0, 7)) << 2)
        | 32'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 9) < 3), a, $urandom, rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
